// File: rtl/keccak_byte_feeder_if.sv
// Byte-stream and keccak word-port signals for keccak_byte_feeder.
// master = byte source / core side, slave = the feeder.
`timescale 1ns/1ps
interface keccak_byte_feeder_if;
   logic [7:0]  byte_in;
   logic        byte_valid;
   logic        byte_last;
   logic        msg_empty;
   logic        byte_ready;
   logic [31:0] in;
   logic        in_ready;
   logic        is_last;
   logic [1:0]  byte_num;
   logic        buffer_full;
   logic        msg_done;

   modport master (
      output byte_in, byte_valid, byte_last, msg_empty, buffer_full,
      input  byte_ready, in, in_ready, is_last, byte_num, msg_done
   );

   modport slave (
      input  byte_in, byte_valid, byte_last, msg_empty, buffer_full,
      output byte_ready, in, in_ready, is_last, byte_num, msg_done
   );
endinterface

// File: rtl/keccak_byte_feeder.sv
// Packs a byte stream big-endian into 32-bit keccak input words,
// adds end-of-message encoding and buffers words in a small FIFO.
`timescale 1ns/1ps
module keccak_byte_feeder #(
   parameter int FIFO_DEPTH = 2
) (
   input  logic clk,
   input  logic reset,
   keccak_byte_feeder_if.slave bus
);
   localparam int AW = $clog2(FIFO_DEPTH);

   typedef enum logic {
      COLLECT,
      DRAIN
   } state_t;

   state_t      r_state, w_state_nx;
   logic [1:0]  r_cnt, w_cnt_nx;
   logic [31:0] r_word, w_word_nx;
   logic        r_pend, w_pend_nx;

   // FIFO entry: {word, last, byte_num}
   logic [34:0] r_mem [FIFO_DEPTH];
   logic [AW:0] r_wp, r_rp;

   logic        w_empty, w_full, w_pop, w_push, w_space;
   logic        w_empty_req, w_take;
   logic [34:0] w_head, w_din;
   logic [31:0] w_packed;
   logic [AW:0] w_one;

   assign w_one   = {{AW{1'b0}}, 1'b1};
   assign w_empty = (r_wp == r_rp);
   assign w_full  = (r_wp[AW-1:0] == r_rp[AW-1:0]) &&
                    (r_wp[AW] != r_rp[AW]);
   assign w_head  = r_mem[r_rp[AW-1:0]];
   assign w_pop   = !w_empty && !bus.buffer_full;
   assign w_space = !w_full || w_pop;

   assign w_empty_req = bus.msg_empty && (r_cnt == 2'd0) &&
                        !r_pend && (r_state == COLLECT);

   assign bus.byte_ready = (r_state == COLLECT) && w_space &&
                           !r_pend && !w_empty_req;

   assign w_take   = bus.byte_valid && bus.byte_ready;
   // lane 31-8*cnt: shift by 8*(3-cnt)
   assign w_packed = r_word |
                     ({24'b0, bus.byte_in} << {~r_cnt, 3'b000});

   always_comb begin
      w_state_nx = r_state;
      w_cnt_nx   = r_cnt;
      w_word_nx  = r_word;
      w_pend_nx  = r_pend;
      w_push     = 1'b0;
      w_din      = '0;
      unique case (r_state)
         COLLECT: begin
            if (r_pend) begin
               if (w_space) begin
                  w_push     = 1'b1;
                  w_din      = {32'b0, 1'b1, 2'd0};
                  w_pend_nx  = 1'b0;
                  w_state_nx = DRAIN;
               end
            end else if (w_empty_req) begin
               if (w_space) begin
                  w_push     = 1'b1;
                  w_din      = {32'b0, 1'b1, 2'd0};
                  w_state_nx = DRAIN;
               end else begin
                  w_pend_nx  = 1'b1;
               end
            end else if (w_take) begin
               if (bus.byte_last && (r_cnt != 2'd3)) begin
                  w_push     = 1'b1;
                  w_din      = {w_packed, 1'b1, r_cnt + 2'd1};
                  w_cnt_nx   = 2'd0;
                  w_word_nx  = '0;
                  w_state_nx = DRAIN;
               end else if (r_cnt == 2'd3) begin
                  // a full last word still needs an empty terminator
                  w_push     = 1'b1;
                  w_din      = {w_packed, 1'b0, 2'd0};
                  w_cnt_nx   = 2'd0;
                  w_word_nx  = '0;
                  w_pend_nx  = bus.byte_last;
               end else begin
                  w_word_nx  = w_packed;
                  w_cnt_nx   = r_cnt + 2'd1;
               end
            end
         end
         DRAIN: begin
            if (w_pop && w_head[2]) begin
               w_state_nx = COLLECT;
               w_cnt_nx   = 2'd0;
               w_word_nx  = '0;
            end
         end
         default: w_state_nx = COLLECT;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= COLLECT;
         r_cnt   <= '0;
         r_word  <= '0;
         r_pend  <= 1'b0;
         r_wp    <= '0;
         r_rp    <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
      end else begin
         r_state <= w_state_nx;
         r_cnt   <= w_cnt_nx;
         r_word  <= w_word_nx;
         r_pend  <= w_pend_nx;
         if (w_push) begin
            r_mem[r_wp[AW-1:0]] <= w_din;
            r_wp <= r_wp + w_one;
         end
         if (w_pop) r_rp <= r_rp + w_one;
      end
   end

   assign bus.in_ready = !w_empty;
   assign bus.in       = w_empty ? 32'b0 : w_head[34:3];
   assign bus.is_last  = !w_empty && w_head[2];
   assign bus.byte_num = w_empty ? 2'd0 : w_head[1:0];
   assign bus.msg_done = w_pop && w_head[2];
endmodule

// File: tb/tb_keccak_byte_feeder.sv
// Directed bench for keccak_byte_feeder: word packing, terminators,
// back-pressure, msg_empty and reset flush.
`timescale 1ns/1ps
module tb_keccak_byte_feeder;
   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   keccak_byte_feeder_if bif();

   keccak_byte_feeder #(.FIFO_DEPTH(2)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bif.slave)
   );

   int checks = 0;
   int errors = 0;
   int n_done = 0;
   logic [7:0]  msg[$];
   logic [34:0] exp_q[$];
   logic [34:0] got_q[$];
   logic [34:0] hold;
   bit          saw_block;

   always @(negedge clk) begin
      if (!reset) begin
         if (bif.in_ready && !bif.buffer_full)
            got_q.push_back({bif.in, bif.is_last, bif.byte_num});
         if (bif.msg_done) n_done++;
      end
   end

   task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      bif.byte_in     = '0;
      bif.byte_valid  = 1'b0;
      bif.byte_last   = 1'b0;
      bif.msg_empty   = 1'b0;
      bif.buffer_full = 1'b0;
      reset = 1'b1;
      repeat (2) tick();
      reset = 1'b0;
      got_q.delete();
      n_done = 0;
   endtask

   task automatic load_str(string s);
      msg.delete();
      for (int i = 0; i < s.len(); i++) msg.push_back(s[i]);
   endtask

   function automatic void model();
      int n;
      logic [31:0] w;
      int k;
      bit l;
      n = msg.size();
      exp_q.delete();
      for (int i = 0; i < n; i += 4) begin
         w = '0;
         k = 0;
         for (int j = 0; j < 4; j++)
            if (i + j < n) begin
               w[31-8*j -: 8] = msg[i+j];
               k++;
            end
         l = (i + 4 >= n) && (n % 4 != 0);
         exp_q.push_back({w, l, l ? 2'(k) : 2'd0});
      end
      if (n % 4 == 0) exp_q.push_back({32'b0, 1'b1, 2'd0});
   endfunction

   task automatic send_byte(logic [7:0] b, logic last);
      int t;
      t = 0;
      bif.byte_in    = b;
      bif.byte_valid = 1'b1;
      bif.byte_last  = last;
      while (1) begin
         @(negedge clk);
         if (bif.byte_ready || t >= 500) break;
         t++;
      end
      chk("byte_wait", t >= 500, 0);
      tick();
      bif.byte_valid = 1'b0;
      bif.byte_last  = 1'b0;
   endtask

   task automatic send_msg();
      for (int i = 0; i < msg.size(); i++)
         send_byte(msg[i], i == msg.size() - 1);
   endtask

   task automatic wait_done(int target);
      int t;
      t = 0;
      while (n_done < target && t < 2000) begin
         tick();
         t++;
      end
      chk("done_wait", n_done >= target, 1);
      repeat (3) tick();
   endtask

   task automatic cmp_words(string tag);
      model();
      chk({tag, "_cnt"}, got_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
         chk(tag, got_q[i], exp_q[i]);
   endtask

   initial begin
      do_reset();
      @(negedge clk);
      chk("rst_in_ready", bif.in_ready, 0);
      chk("rst_byte_ready", bif.byte_ready, 1);
      chk("rst_in", bif.in, 0);
      chk("rst_is_last", bif.is_last, 0);
      chk("rst_byte_num", bif.byte_num, 0);
      chk("rst_done", bif.msg_done, 0);

      // 43 bytes: short last word
      tick();
      load_str("The quick brown fox jumps over the lazy dog");
      send_msg();
      wait_done(1);
      chk("fox_n", got_q.size(), 11);
      chk("fox_w0", got_q[0][34:3], 32'h54686520);
      chk("fox_last", got_q[10], {32'h646F6700, 1'b1, 2'd3});
      cmp_words("fox");

      // 44 bytes: empty terminator word
      do_reset();
      load_str("The quick brown fox jumps over the lazy dog.");
      send_msg();
      wait_done(1);
      repeat (10) tick();
      chk("dot_w10", got_q[10], {32'h646F672E, 1'b0, 2'd0});
      chk("dot_term", got_q[11], {32'h0, 1'b1, 2'd0});
      chk("dot_done", n_done, 1);
      cmp_words("dot");

      // A1..A5 with core stalled, byte_valid held in DRAIN
      do_reset();
      msg = '{8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5};
      bif.buffer_full = 1'b1;
      send_msg();
      bif.byte_in    = 8'hFF;
      bif.byte_valid = 1'b1;
      repeat (3) begin
         @(negedge clk);
         chk("drain_ready", bif.byte_ready, 0);
         chk("drain_hold", bif.in, 32'hA1A2A3A4);
      end
      tick();
      bif.byte_valid  = 1'b0;
      bif.buffer_full = 1'b0;
      wait_done(1);
      chk("a5_w0", got_q[0], {32'hA1A2A3A4, 1'b0, 2'd0});
      chk("a5_w1", got_q[1], {32'hA5000000, 1'b1, 2'd1});
      cmp_words("a5");

      // zero-length message, msg_empty held two cycles
      do_reset();
      msg.delete();
      bif.msg_empty = 1'b1;
      @(negedge clk);
      chk("empty_ready", bif.byte_ready, 0);
      tick();
      tick();
      bif.msg_empty = 1'b0;
      wait_done(1);
      repeat (5) tick();
      chk("empty_n", got_q.size(), 1);
      chk("empty_w", got_q[0], {32'h0, 1'b1, 2'd0});
      cmp_words("empty");

      // 144 bytes with a 10-cycle core stall
      do_reset();
      msg.delete();
      for (int i = 0; i < 144; i++) msg.push_back(8'(i * 7 + 3));
      fork
         send_msg();
         begin
            repeat (40) tick();
            bif.buffer_full = 1'b1;
            saw_block = 1'b0;
            @(negedge clk);
            hold = {bif.in, bif.is_last, bif.byte_num};
            repeat (9) begin
               @(negedge clk);
               chk("stall_hold", {bif.in, bif.is_last, bif.byte_num}, hold);
               if (!bif.byte_ready) saw_block = 1'b1;
            end
            tick();
            bif.buffer_full = 1'b0;
            chk("stall_block", saw_block, 1);
         end
      join
      wait_done(1);
      chk("long_n", got_q.size(), 37);
      chk("long_term", got_q[36], {32'h0, 1'b1, 2'd0});
      chk("long_prev_last", got_q[35][2], 0);
      cmp_words("long");

      // reset with queued words, then a fresh 5-byte message
      do_reset();
      bif.buffer_full = 1'b1;
      for (int i = 0; i < 8; i++) send_byte(8'(8'h30 + i), 1'b0);
      @(negedge clk);
      chk("q_in_ready", bif.in_ready, 1);
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      @(negedge clk);
      chk("rst2_in_ready", bif.in_ready, 0);
      chk("rst2_byte_ready", bif.byte_ready, 1);
      chk("rst2_done", bif.msg_done, 0);
      tick();
      bif.buffer_full = 1'b0;
      got_q.delete();
      n_done = 0;
      msg = '{8'h11, 8'h12, 8'h13, 8'h14, 8'h15};
      send_msg();
      wait_done(1);
      chk("post_w0", got_q[0], {32'h11121314, 1'b0, 2'd0});
      chk("post_w1", got_q[1], {32'h15000000, 1'b1, 2'd1});
      cmp_words("post");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
